// File: rtl/mips_tx_buffer_if.sv
// Core/UART-side bus of the MIPS transmit buffer: word push port, FIFO status
// and the per-beat UART handshake.
interface mips_tx_buffer_if #(
   parameter int unsigned WORD_LENGTH = 32,
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned BYTE_WIDTH  = 8
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic                   push;
   logic [WORD_LENGTH-1:0] push_data;
   logic                   full;
   logic                   empty;
   logic [AW:0]            count;
   logic                   overflow;
   logic [BYTE_WIDTH-1:0]  tx_data;
   logic                   tx_start;
   logic                   TX_flag;
   logic                   busy;

   // master: core + UART side; slave: the buffer
   modport master (
      output push, push_data, TX_flag,
      input  full, empty, count, overflow, tx_data, tx_start, busy
   );

   modport slave (
      input  push, push_data, TX_flag,
      output full, empty, count, overflow, tx_data, tx_start, busy
   );
endinterface

// File: rtl/mips_tx_buffer.sv
// Word FIFO plus beat serialiser between the MIPS core and the UART.
// Define TXBUF_MSB_FIRST_EN to send the most-significant byte first.
module mips_tx_buffer #(
   parameter int unsigned WORD_LENGTH = 32,
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned BYTE_WIDTH  = 8
) (
   input  logic             clk,
   input  logic             reset,
   mips_tx_buffer_if.slave  bus
);
   localparam int unsigned BEATS = WORD_LENGTH / BYTE_WIDTH;
   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

   state_t                 state;
   logic [WORD_LENGTH-1:0] mem [DEPTH];
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic [AW:0]            count;
   logic                   full;
   logic                   empty;
   logic                   overflow;
   logic [WORD_LENGTH-1:0] sr;
   logic [BW-1:0]          beat;
   logic                   tx_start;
   logic                   busy;

   logic                   push_ok_c;
   logic                   pop_c;
   logic [AW:0]            count_nxt_c;

   // Full check uses the registered flag, so a same-edge pop never frees a slot
   always_comb begin
      push_ok_c   = bus.push && !full;
      pop_c       = (state == IDLE) && !empty;
      count_nxt_c = count;
      if (push_ok_c && !pop_c)
         count_nxt_c = count + (AW+1)'(1);
      else if (!push_ok_c && pop_c)
         count_nxt_c = count - (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (push_ok_c)
         mem[wr_ptr] <= bus.push_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (push_ok_c)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop_c)
            rd_ptr <= rd_ptr + AW'(1);
         if (bus.push && full)
            overflow <= 1'b1;
         count <= count_nxt_c;
         full  <= (count_nxt_c == (AW+1)'(DEPTH));
         empty <= (count_nxt_c == '0);
      end
   end

   // Serialiser: one tx_start per beat, next beat only after TX_flag in WAIT
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         sr       <= '0;
         beat     <= '0;
         tx_start <= 1'b0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  sr       <= mem[rd_ptr];
                  beat     <= '0;
                  state    <= SEND;
                  tx_start <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            SEND: begin
               state    <= WAIT;
               tx_start <= 1'b0;
            end
            WAIT: begin
               if (bus.TX_flag) begin
                  if (beat == BW'(BEATS-1)) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
`ifdef TXBUF_MSB_FIRST_EN
                     sr <= sr << BYTE_WIDTH;
`else
                     sr <= sr >> BYTE_WIDTH;
`endif
                     beat     <= beat + BW'(1);
                     state    <= SEND;
                     tx_start <= 1'b1;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               tx_start <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

`ifdef TXBUF_MSB_FIRST_EN
   assign bus.tx_data = sr[WORD_LENGTH-1 -: BYTE_WIDTH];
`else
   assign bus.tx_data = sr[BYTE_WIDTH-1:0];
`endif
   assign bus.tx_start = tx_start;
   assign bus.busy     = busy;
   assign bus.full     = full;
   assign bus.empty    = empty;
   assign bus.count    = count;
   assign bus.overflow = overflow;
endmodule
